// File: rtl/sram_mem_controller.sv
// Multi-cycle bridge from the 32-bit MEM stage to a 16-bit asynchronous SRAM.
// Each word access is split into a low-half then high-half SRAM cycle; ready=0 freezes the pipeline.
module sram_mem_controller #(
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_BASE   = 1024,
  parameter int SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [15:0]            SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam int IDX_W = SRAM_ADDR_W - 1;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_wr;
  logic [IDX_W-1:0] r_word_idx;
  logic [31:0]      r_wdata;
  logic [31:0]      r_read_data;

  logic             w_req;
  logic             w_last;
  logic             w_in_phase;
  logic             w_dq_oe;
  logic [15:0]      w_dq_out;
  logic [IDX_W-1:0] w_word_idx;

  assign w_req      = wr_en | rd_en;
  assign w_last     = (r_cnt == CNT_LAST);
  // Out-of-range addresses simply wrap: the index is truncated to the SRAM size.
  assign w_word_idx = IDX_W'((address - 32'(DATA_BASE)) >> 2);

  // NOTE: every register here is assigned with <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_wr     <= 1'b0;
      r_word_idx  <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_is_wr    <= wr_en;
            r_word_idx <= w_word_idx;
            r_wdata    <= write_data;
            r_cnt      <= '0;
            r_state    <= S_LO;
          end
        end
        S_LO: begin
          if (w_last) begin
            if (!r_is_wr) r_read_data[15:0] <= SRAM_DQ;
            r_cnt   <= '0;
            r_state <= S_HI;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HI: begin
          if (w_last) begin
            if (!r_is_wr) r_read_data[31:16] <= SRAM_DQ;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus controls decode straight from the state flops, so reset releases the bus immediately.
  // NOTE: each always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ready      = 1'b0;
    w_in_phase = 1'b0;
    if (r_state == S_DONE || (r_state == S_IDLE && !w_req)) ready = 1'b1;
    if (r_state == S_LO || r_state == S_HI) w_in_phase = 1'b1;
  end

  // WE_N rises on the last wait cycle so address and data are stable at the strobe edge.
  assign SRAM_WE_N = ~(w_in_phase & r_is_wr & ~w_last);
  assign SRAM_OE_N = ~(w_in_phase & ~r_is_wr);
  assign w_dq_oe   = w_in_phase & r_is_wr;
  assign w_dq_out  = (r_state == S_HI) ? r_wdata[31:16] : r_wdata[15:0];
  assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'bz;
  assign SRAM_ADDR = {r_word_idx, (r_state == S_HI)};
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign read_data = r_read_data;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench: a driver pushes expected results from a word-level memory model,
// a monitor pops and compares each time ready rises at the end of an access.
module tb_sram_mem_controller;

  localparam int W    = 2;
  localparam int BASE = 1024;
  localparam int LAT  = 2 * W + 1;
  localparam int NWORDS = 1 << 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  always #5 clk = ~clk;

  sram_mem_controller #(.WAIT_CYCLES(W), .DATA_BASE(BASE), .SRAM_ADDR_W(18)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
    .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  // Asynchronous SRAM device: drives the bus on reads, commits a write on the WE_N rising edge.
  logic [15:0] sram [0:(1<<18)-1];
  logic        probe_en;
  logic [17:0] wr_addr_s;
  logic [15:0] wr_data_s;

  assign sram_dq = (!oe_n && we_n && !ce_n) ? sram[sram_addr] : 16'hzzzz;
  assign sram_dq = probe_en ? 16'h5A5A : 16'hzzzz;

  always @(negedge clk) if (!we_n) begin wr_addr_s = sram_addr; wr_data_s = sram_dq; end
  always @(posedge we_n) if (!rst) sram[wr_addr_s] = wr_data_s;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word-level reference model.
  logic [31:0] ref_words [int unsigned];
  logic [31:0] ref_last_rd = '0;

  typedef struct {
    logic [31:0] rdata;
    int          done_cyc;
    int          we_lows;
    int          oe_lows;
  } exp_t;
  exp_t sb[$];

  function automatic int unsigned word_of(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - 32'(BASE);
    return (off >> 2) % NWORDS;
  endfunction

  // Monitor: an access ends where ready goes 0 -> 1 outside reset.
  logic prev_ready = 1'b1;
  int   we_cnt = 0, oe_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ready = 1'b1; we_cnt = 0; oe_cnt = 0;
    end else begin
      if (!we_n) we_cnt++;
      if (!oe_n) oe_cnt++;
      if (ready && !prev_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("latency_cycle", 32'(cyc), 32'(e.done_cyc));
          check("read_data", read_data, e.rdata);
          check("we_n_low_cycles", 32'(we_cnt), 32'(e.we_lows));
          check("oe_n_low_cycles", 32'(oe_cnt), 32'(e.oe_lows));
        end
        we_cnt = 0; oe_cnt = 0;
      end
      prev_ready = ready;
    end
  end

  // Drive a request in the cycle after the next rising edge and record what it must produce.
  task automatic issue(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int unsigned idx;
    @(posedge clk); #1;
    wr_en = w; rd_en = r; address = a; write_data = d;
    idx = word_of(a);
    e.done_cyc = cyc + LAT;
    if (w) begin
      ref_words[idx] = d;
      e.we_lows = 2 * (W - 1);
      e.oe_lows = 0;
    end else begin
      ref_last_rd = ref_words.exists(idx) ? ref_words[idx] : 32'h0;
      e.we_lows = 0;
      e.oe_lows = 2 * W;
    end
    e.rdata = ref_last_rd;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic check_dq_z(input string name);
    probe_en = 1'b1;
    #1 check(name, {16'h0, sram_dq}, 32'h5A5A);
    probe_en = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0; probe_en = 1'b0;
    for (int i = 0; i < (1 << 18); i++) sram[i] = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_ready", {31'h0, ready}, 32'd1);
    check("reset_read_data", read_data, 32'h0);
    check("reset_we_n", {31'h0, we_n}, 32'd1);
    check("reset_oe_n", {31'h0, oe_n}, 32'd1);
    check("tied_ce_ub_lb", {29'h0, ce_n, ub_n, lb_n}, 32'h0);
    check_dq_z("reset_dq_z");

    issue(1, 0, 32'd1024, 32'hDEADBEEF); wait_done();
    go_idle(2);
    check("sram0_beef", {16'h0, sram[0]}, 32'hBEEF);
    check("sram1_dead", {16'h0, sram[1]}, 32'hDEAD);
    issue(0, 1, 32'd1024, 32'h0); wait_done();
    go_idle(1);

    // Request held through DONE: each new access starts in the IDLE cycle right after.
    issue(1, 0, 32'd1028, 32'hCAFEF00D); wait_done();
    issue(1, 0, 32'd1028, 32'h0BADC0DE); wait_done();
    issue(0, 1, 32'd1028, 32'h0); wait_done();
    go_idle(2);
    check("sram2_lo", {16'h0, sram[2]}, 32'hC0DE);
    check("sram3_hi", {16'h0, sram[3]}, 32'h0BAD);
    check("sram0_kept", {16'h0, sram[0]}, 32'hBEEF);
    check("sram1_kept", {16'h0, sram[1]}, 32'hDEAD);

    // Both enables: write wins, read_data must hold the previous load.
    issue(1, 1, 32'd1032, 32'h12345678); wait_done();
    go_idle(2);
    check("both_sram4", {16'h0, sram[4]}, 32'h5678);
    check("both_sram5", {16'h0, sram[5]}, 32'h1234);

    // Reset during the high-half write strobe; high half is unchanged data either way.
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1032; write_data = 32'h1234ABCD;
    @(posedge clk); #1 wr_en = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("hi_strobe_active", {31'h0, we_n}, 32'd0);
    rst = 1'b1;
    #1;
    check("abort_we_n", {31'h0, we_n}, 32'd1);
    check("abort_oe_n", {31'h0, oe_n}, 32'd1);
    check("abort_ready", {31'h0, ready}, 32'd1);
    check("abort_read_data", read_data, 32'h0);
    check_dq_z("abort_dq_z");
    ref_words[word_of(32'd1032)] = 32'h1234ABCD;
    ref_last_rd = 32'h0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    issue(0, 1, 32'd1032, 32'h0); wait_done();
    go_idle(1);

    // Randomized traffic, including enables both high and wrapping addresses.
    for (int i = 0; i < 60; i++) begin
      int unsigned op, k;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      k  = $urandom_range(0, 7);
      a  = ($urandom_range(0, 7) == 0) ? 32'(BASE) + 32'(4 * (NWORDS + k)) : 32'(BASE) + 32'(4 * k);
      if (op < 4)      issue(1, 0, a, $urandom);
      else if (op < 9) issue(0, 1, a, $urandom);
      else             issue(1, 1, a, $urandom);
      wait_done();
      if ($urandom_range(0, 1) == 1) go_idle($urandom_range(0, 2));
    end
    go_idle(2);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check_dq_z("final_dq_z");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
    $fatal(1, "timeout");
  end

endmodule
